button_conditioner: RTL and testbench

//  Conditions the raw board push-buttons before they reach mode selection and game control.

---
 rtl/button_conditioner_pkg.sv | 8 +
 rtl/debounce_channel.sv | 62 ++++++
 rtl/button_conditioner.sv | 42 ++++
 tb/tb_button_conditioner.sv | 137 +++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared clock and timing constants for the push-button conditioning path.
package button_conditioner_pkg;

  localparam int unsigned CLK_HZ                  = 100_000_000;
  // 10 ms of stable samples at the system clock rate
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and registered press/release pulses.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_next_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept_c;
  logic             release_next_c;

  // Any sample matching the current level restarts the count; DC-1 resolves to accept
  always_comb begin
    cnt_nxt  = '0;
    accept_c = 1'b0;
    if (s2 != level_o) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        accept_c = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign press_next_c   = accept_c & s2;
  assign release_next_c = accept_c & ~s2;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      s1        <= button_i;
      s2        <= s1;
      cnt       <= cnt_nxt;
      press_o   <= press_next_c;
      release_o <= release_next_c;
      if (accept_c) begin
        level_o <= s2;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces N independent push-buttons into clean levels plus press/release pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [N_BUTTONS-1:0] buttons_i,
  output logic [N_BUTTONS-1:0] buttons_o,
  output logic [N_BUTTONS-1:0] press_o,
  output logic [N_BUTTONS-1:0] release_o,
  output logic                 any_press_o
);

  logic [N_BUTTONS-1:0] press_next_c;

  for (genvar k = 0; k < N_BUTTONS; k++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock_i     (clock_i),
      .reset_n_i   (reset_n_i),
      .button_i    (buttons_i[k]),
      .level_o     (buttons_o[k]),
      .press_o     (press_o[k]),
      .release_o   (release_o[k]),
      .press_next_c(press_next_c[k])
    );
  end

  // Built from the channels' next-pulse values so it lines up with press_o
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      any_press_o <= 1'b0;
    end else begin
      any_press_o <= |press_next_c;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8 (edge-to-output latency 10).
module tb_button_conditioner;

  localparam int unsigned NB  = 4;
  localparam int unsigned DC  = 8;
  localparam int unsigned LAT = DC + 2;

  logic          clock_i;
  logic          reset_n_i;
  logic [NB-1:0] buttons_i;
  logic [NB-1:0] buttons_o;
  logic [NB-1:0] press_o;
  logic [NB-1:0] release_o;
  logic          any_press_o;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .buttons_i  (buttons_i),
    .buttons_o  (buttons_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .any_press_o(any_press_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel);
    chk({tag, ".buttons"}, buttons_o, lvl);
    chk({tag, ".press"}, press_o, prs);
    chk({tag, ".release"}, release_o, rel);
    chk({tag, ".any"}, {3'b000, any_press_o}, {3'b000, |prs});
  endtask

  initial begin
    reset_n_i = 1'b0;
    buttons_i = 4'h0;

    // 1: buttons held through reset, then accepted as a fresh press
    buttons_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("t1_reset", 4'h0, 4'h0, 4'h0);
    end
    reset_n_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("t1_rel", (k >= LAT) ? 4'hF : 4'h0, (k == LAT) ? 4'hF : 4'h0,
              4'h0);
    end
    buttons_i = 4'h0;
    for (int k = 1; k <= 12; k++) tick();
    chk_all("t1_clear", 4'h0, 4'h0, 4'h0);

    // 2: single clean press on button 2, held 20 cycles
    buttons_i[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("t2_press", (k >= LAT) ? 4'b0100 : 4'h0,
              (k == LAT) ? 4'b0100 : 4'h0, 4'h0);
    end

    // 4: release of button 2
    buttons_i[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("t4_release", (k < LAT) ? 4'b0100 : 4'h0, 4'h0,
              (k == LAT) ? 4'b0100 : 4'h0);
    end

    // 3: button 0 bouncing every 3 cycles never gets through, then settles high
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) buttons_i[0] = ~buttons_i[0];
      tick();
      chk_all("t3_bounce", 4'h0, 4'h0, 4'h0);
    end
    buttons_i[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("t3_settle", (k >= LAT) ? 4'b0001 : 4'h0,
              (k == LAT) ? 4'b0001 : 4'h0, 4'h0);
    end
    buttons_i = 4'h0;
    for (int k = 1; k <= 12; k++) tick();
    chk_all("t3_clear", 4'h0, 4'h0, 4'h0);

    // 5: simultaneous press on buttons 3 and 1
    buttons_i = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("t5_simul", (k >= LAT) ? 4'b1010 : 4'h0,
              (k == LAT) ? 4'b1010 : 4'h0, 4'h0);
    end
    buttons_i = 4'h0;
    for (int k = 1; k <= 12; k++) tick();
    chk_all("t5_clear", 4'h0, 4'h0, 4'h0);

    // 6: reset on edge 6 discards the partial count
    buttons_i[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("t6_pre", 4'h0, 4'h0, 4'h0);
    end
    reset_n_i = 1'b0;
    tick();
    chk_all("t6_reset", 4'h0, 4'h0, 4'h0);
    reset_n_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("t6_post", (k >= LAT) ? 4'b0010 : 4'h0,
              (k == LAT) ? 4'b0010 : 4'h0, 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
